// File: rtl/vl53l0x_init_sequencer.sv
// vl53l0x_init_sequencer
//   Walks a table of register writes held in an external synchronous ROM and
//   hands each one to a register-write stage. Failed writes are retried a
//   bounded number of times. The sequence ends in DONE when every entry has
//   been written, or in FAIL on the first entry that runs out of retries.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   start          pulse; runs the sequence from entry 0 (ignored while busy)
//   abort          synchronous return to IDLE, wins over start
//   rom_addr       entry index presented to the ROM
//   rom_data       {reg_address, data}, valid one cycle after rom_addr
//   wr_start       one-cycle request to the write stage
//   wr_dev_address constant DEV_ADDRESS
//   wr_reg_address latched register address of the current entry
//   wr_data        latched data byte of the current entry
//   wr_done        write stage completed the write
//   wr_failure     write stage saw a missed ACK or its own timeout
//   busy           high in every state except IDLE, DONE and FAIL
//   init_done      high in DONE
//   init_error     high in FAIL
//   fail_index     entry that exhausted its retries
//   state_dbg      current FSM state encoding
//
// Handshake: wr_start is high for exactly one cycle (ISSUE). From the next
// cycle on, the sequencer waits in WAIT for a one-cycle wr_done or
// wr_failure; both inputs are ignored outside WAIT. A cycle with both high
// counts as a failure.
module vl53l0x_init_sequencer #(
  parameter logic [6:0] DEV_ADDRESS    = 7'h29,
  parameter int         NUM_ENTRIES    = 16,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         GAP_CYCLES     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        wr_start,
  output logic [6:0]  wr_dev_address,
  output logic [7:0]  wr_reg_address,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        wr_failure,
  output logic        busy,
  output logic        init_done,
  output logic        init_error,
  output logic [7:0]  fail_index,
  output logic [2:0]  state_dbg
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    LAST_IDX  = 8'(NUM_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6,
    S_FAIL  = 3'd7
  } state_t;

  state_t        state;
  logic [7:0]    index;
  logic [RW-1:0] retry;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;

  assign wr_dev_address = DEV_ADDRESS;
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      index          <= '0;
      retry          <= '0;
      tmo_cnt        <= '0;
      gap_cnt        <= '0;
      rom_addr       <= '0;
      wr_start       <= 1'b0;
      wr_reg_address <= '0;
      wr_data        <= '0;
      busy           <= 1'b0;
      init_done      <= 1'b0;
      init_error     <= 1'b0;
      fail_index     <= '0;
    end else if (abort) begin
      // Abandon whatever is in flight; an entry sitting in LATCH never
      // reaches ISSUE, so no write request leaves the block.
      state      <= S_IDLE;
      wr_start   <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state      <= S_FETCH;
            index      <= '0;
            retry      <= '0;
            fail_index <= '0;
            rom_addr   <= '0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
            init_error <= 1'b0;
          end
        end

        // rom_addr already holds index; the ROM answers during LATCH.
        S_FETCH: state <= S_LATCH;

        S_LATCH: begin
          wr_reg_address <= rom_data[15:8];
          wr_data        <= rom_data[7:0];
          wr_start       <= 1'b1;
          state          <= S_ISSUE;
        end

        S_ISSUE: begin
          wr_start <= 1'b0;
          tmo_cnt  <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          // Failure is checked first so a simultaneous done does not mask it.
          if (wr_failure || (tmo_cnt == TMO_LAST)) begin
            if (retry < RETRY_MAX) begin
              retry   <= retry + RW'(1);
              gap_cnt <= '0;
              state   <= S_GAP;
            end else begin
              fail_index <= index;
              busy       <= 1'b0;
              init_error <= 1'b1;
              state      <= S_FAIL;
            end
          end else if (wr_done) begin
            index   <= index + 8'd1;
            retry   <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (index == LAST_IDX) begin
              busy      <= 1'b0;
              init_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              rom_addr <= index;
              state    <= S_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
